// File: rtl/adc_mv_bcd.sv
// adc_mv_bcd: ADC code -> millivolts -> 4-digit packed BCD.
// Optional ADC_AVG4_EN: launch a 4-sample running average instead of the raw code.
module adc_mv_bcd #(
  parameter int ADC_W   = 8,
  parameter int VREF_MV = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic [15:0]      bcd_data,
  output logic             bcd_valid,
  output logic             busy
);

  localparam int          PW   = ADC_W + 14;
  localparam logic [13:0] VREF = 14'(VREF_MV);

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    CONV,
    DONE
  } state_t;

  state_t state;
  state_t state_d;

  logic [ADC_W-1:0] code_q;
  logic [ADC_W-1:0] launch_code;
  logic [13:0]      bin_q;
  logic [15:0]      acc_q;
  logic [15:0]      acc_adj;
  logic [3:0]       step_q;
  logic             pend_q;
  logic             launch;
  logic             pend_set;
  logic             pend_clr;
  logic [PW-1:0]    prod;
  logic [13:0]      mv;

`ifdef ADC_AVG4_EN
  logic [ADC_W-1:0] hist_q [4];
  logic [ADC_W+1:0] sum;

  // The sample arriving this cycle displaces the oldest entry.
  always_comb begin
    sum = '0;
    if (adc_valid) begin
      sum = (ADC_W+2)'(adc_data)
          + (ADC_W+2)'(hist_q[0])
          + (ADC_W+2)'(hist_q[1])
          + (ADC_W+2)'(hist_q[2]);
    end else begin
      sum = (ADC_W+2)'(hist_q[0])
          + (ADC_W+2)'(hist_q[1])
          + (ADC_W+2)'(hist_q[2])
          + (ADC_W+2)'(hist_q[3]);
    end
  end

  assign launch_code = ADC_W'(sum >> 2);

  // Every strobe shifts into the history, regardless of state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
      end
    end else if (adc_valid) begin
      hist_q[0] <= adc_data;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
      hist_q[3] <= hist_q[2];
    end
  end

  // Pending slot only remembers that a request arrived.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else if (pend_set) begin
      pend_q <= 1'b1;
    end else if (pend_clr) begin
      pend_q <= 1'b0;
    end
  end
`else
  logic [ADC_W-1:0] pend_code_q;

  assign launch_code = adc_valid ? adc_data : pend_code_q;

  // Single-entry pending slot; newest sample wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_code_q <= '0;
    end else if (pend_set) begin
      pend_q      <= 1'b1;
      pend_code_q <= adc_data;
    end else if (pend_clr) begin
      pend_q      <= 1'b0;
    end
  end
`endif

  assign prod = PW'(code_q) * PW'(VREF);
  assign mv   = 14'(prod >> ADC_W);
  assign busy = (state != IDLE);

  // Add-3 correction on every BCD digit that is 5 or more.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) begin
        acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and launch/pending control.
  always_comb begin
    state_d  = state;
    launch   = 1'b0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (adc_valid) begin
          launch  = 1'b1;
          state_d = SCALE;
        end
      end
      SCALE: begin
        pend_set = adc_valid;
        state_d  = CONV;
      end
      CONV: begin
        pend_set = adc_valid;
        if (step_q == 4'd13) begin
          state_d = DONE;
        end
      end
      DONE: begin
        pend_clr = 1'b1;
        if (adc_valid || pend_q) begin
          launch  = 1'b1;
          state_d = SCALE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scale and double-dabble datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q <= '0;
      bin_q  <= '0;
      acc_q  <= '0;
      step_q <= '0;
    end else begin
      if (launch) begin
        code_q <= launch_code;
      end
      if (state == SCALE) begin
        bin_q  <= mv;
        acc_q  <= '0;
        step_q <= '0;
      end else if (state == CONV) begin
        {acc_q, bin_q} <= {acc_adj, bin_q} << 1;
        step_q         <= step_q + 4'd1;
      end
    end
  end

  // Display-facing result, updated only when a conversion ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_data  <= 16'h0000;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= (state == DONE);
      if (state == DONE) begin
        bcd_data <= acc_q;
      end
    end
  end

endmodule
